// File: rtl/accum_array.sv
// -----------------------------------------------------------------------------
// accum_array
// Multi-lane signed accumulator for the convolution datapath. Each group of
// num_terms input vectors is summed per lane on top of a preloaded bias. The
// block can saturate or wrap on overflow, and it keeps a sticky overflow flag
// per lane. The finished vector is presented through a valid/ready output
// register, so the downstream requantiser can stall it without losing data.
//
// Ports
//   i_clk            clock
//   i_rst_n          asynchronous active-low reset
//   i_cfg_num_terms  terms per result (0 behaves as 1), latched at group start
//   i_cfg_sat_en     1 = saturate, 0 = wrap; latched at group start
//   i_bias           signed bias preloaded into every lane at group start
//   i_clear          synchronous abort of the group in progress
//   i_valid/o_ready  input term vector handshake
//   i_data           N_LANE signed terms, lane k at [k*IN_WIDTH +: IN_WIDTH]
//   o_valid/i_ready  result vector handshake
//   o_data           N_LANE signed sums, lane k at [k*ACC_WIDTH +: ACC_WIDTH]
//   o_overflow       per-lane sticky overflow of the group held in o_data
//   o_term_cnt       terms accepted so far in the current group
// -----------------------------------------------------------------------------
module accum_array #(
  parameter int IN_WIDTH  = 16,
  parameter int ACC_WIDTH = 32,
  parameter int N_LANE    = 4,
  parameter int CNT_WIDTH = 8
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic [CNT_WIDTH-1:0]        i_cfg_num_terms,
  input  logic                        i_cfg_sat_en,
  input  logic [ACC_WIDTH-1:0]        i_bias,
  input  logic                        i_clear,
  input  logic                        i_valid,
  output logic                        o_ready,
  input  logic [N_LANE*IN_WIDTH-1:0]  i_data,
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic [N_LANE*ACC_WIDTH-1:0] o_data,
  output logic [N_LANE-1:0]           o_overflow,
  output logic [CNT_WIDTH-1:0]        o_term_cnt
);

  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ACC_WIDTH-1:0] ACC_MAX  = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN  = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  typedef enum logic [0:0] {
    ACCUM      = 1'b0,
    ACCUM_HOLD = 1'b1
  } state_t;

  state_t                      r_state;
  state_t                      w_state_nxt;
  logic [CNT_WIDTH-1:0]        r_cnt;
  logic [CNT_WIDTH-1:0]        r_num_terms;
  logic                        r_sat_en;
  logic [N_LANE*ACC_WIDTH-1:0] r_acc;
  logic [N_LANE-1:0]           r_ovf;
  logic [N_LANE*ACC_WIDTH-1:0] r_out_data;
  logic [N_LANE-1:0]           r_out_ovf;

  logic                        w_first;
  logic [CNT_WIDTH-1:0]        w_cfg_num;
  logic [CNT_WIDTH-1:0]        w_num_eff;
  logic                        w_sat_eff;
  logic                        w_last;
  logic                        w_ready;
  logic                        w_valid;
  logic                        w_in_xfer;
  logic                        w_final_xfer;
  logic                        w_out_xfer;
  logic [N_LANE*ACC_WIDTH-1:0] w_acc_nxt;
  logic [N_LANE-1:0]           w_ovf_nxt;

  // One lane add at ACC_WIDTH+1 bits. Returns {overflow, result}. Overflow
  // means the two top bits of the wide sum disagree.
  function automatic logic [ACC_WIDTH:0] lane_add(
    input logic [ACC_WIDTH-1:0] base,
    input logic [IN_WIDTH-1:0]  term,
    input logic                 sat_en
  );
    logic [ACC_WIDTH:0]   sum;
    logic                 ovf;
    logic [ACC_WIDTH-1:0] res;
    sum = {base[ACC_WIDTH-1], base}
        + {{(ACC_WIDTH+1-IN_WIDTH){term[IN_WIDTH-1]}}, term};
    ovf = sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1];
    if (ovf && sat_en) begin
      res = sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
    end else begin
      res = sum[ACC_WIDTH-1:0];
    end
    return {ovf, res};
  endfunction

  // Group bookkeeping. While the counter is 0, the live config applies,
  // because that is the value that gets latched on the first transfer.
  always_comb begin
    w_first   = (r_cnt == CNT_ZERO);
    w_cfg_num = (i_cfg_num_terms == CNT_ZERO) ? CNT_ONE : i_cfg_num_terms;
    w_num_eff = w_first ? w_cfg_num : r_num_terms;
    w_sat_eff = w_first ? i_cfg_sat_en : r_sat_en;
    w_last    = (r_cnt == (w_num_eff - CNT_ONE));
  end

  // Transfer qualifiers. i_clear overrides an input transfer in the same cycle.
  always_comb begin
    w_in_xfer    = i_valid && w_ready && !i_clear;
    w_final_xfer = w_in_xfer && w_last;
    w_out_xfer   = w_valid && i_ready;
  end

  // Per-lane next accumulator and sticky overflow values.
  always_comb begin
    logic [ACC_WIDTH:0] v_res;
    v_res     = {(ACC_WIDTH+1){1'b0}};
    w_acc_nxt = {(N_LANE*ACC_WIDTH){1'b0}};
    w_ovf_nxt = {N_LANE{1'b0}};
    for (int k = 0; k < N_LANE; k++) begin
      v_res = lane_add(w_first ? i_bias : r_acc[k*ACC_WIDTH +: ACC_WIDTH],
                       i_data[k*IN_WIDTH +: IN_WIDTH], w_sat_eff);
      w_acc_nxt[k*ACC_WIDTH +: ACC_WIDTH] = v_res[ACC_WIDTH-1:0];
      w_ovf_nxt[k] = v_res[ACC_WIDTH] | (w_first ? 1'b0 : r_ovf[k]);
    end
  end

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ACCUM;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state. A final term that lands together with an output transfer
  // keeps the register full, because it reloads with the new result.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ACCUM: begin
        if (w_final_xfer) begin
          w_state_nxt = ACCUM_HOLD;
        end else begin
          w_state_nxt = ACCUM;
        end
      end
      ACCUM_HOLD: begin
        if (w_out_xfer && !w_final_xfer) begin
          w_state_nxt = ACCUM;
        end else begin
          w_state_nxt = ACCUM_HOLD;
        end
      end
      default: w_state_nxt = ACCUM;
    endcase
  end

  // FSM outputs. A stall happens only when the final term would need a full,
  // non-draining output register. Non-final terms always pass.
  always_comb begin
    w_valid = 1'b0;
    w_ready = 1'b1;
    case (r_state)
      ACCUM: begin
        w_valid = 1'b0;
        w_ready = 1'b1;
      end
      ACCUM_HOLD: begin
        w_valid = 1'b1;
        if (!i_ready && w_last) begin
          w_ready = 1'b0;
        end else begin
          w_ready = 1'b1;
        end
      end
      default: begin
        w_valid = 1'b0;
        w_ready = 1'b1;
      end
    endcase
  end

  // Term counter, latched group config, lane accumulators and sticky flags.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt       <= CNT_ZERO;
      r_num_terms <= CNT_ONE;
      r_sat_en    <= 1'b0;
      r_acc       <= {(N_LANE*ACC_WIDTH){1'b0}};
      r_ovf       <= {N_LANE{1'b0}};
    end else if (i_clear) begin
      r_cnt <= CNT_ZERO;
      r_acc <= {(N_LANE*ACC_WIDTH){1'b0}};
      r_ovf <= {N_LANE{1'b0}};
    end else if (w_in_xfer) begin
      r_cnt <= w_last ? CNT_ZERO : (r_cnt + CNT_ONE);
      r_acc <= w_acc_nxt;
      r_ovf <= w_ovf_nxt;
      if (w_first) begin
        r_num_terms <= w_cfg_num;
        r_sat_en    <= i_cfg_sat_en;
      end
    end
  end

  // Output register. It loads only on a final-term transfer; i_clear leaves it alone.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_out_data <= {(N_LANE*ACC_WIDTH){1'b0}};
      r_out_ovf  <= {N_LANE{1'b0}};
    end else if (w_final_xfer) begin
      r_out_data <= w_acc_nxt;
      r_out_ovf  <= w_ovf_nxt;
    end
  end

  assign o_valid    = w_valid;
  assign o_ready    = w_ready;
  assign o_data     = r_out_data;
  assign o_overflow = r_out_ovf;
  assign o_term_cnt = r_cnt;

endmodule

// File: tb/tb_accum_array.sv
module tb_accum_array;

  localparam int IW = 16;
  localparam int AW = 16;
  localparam int NL = 4;
  localparam int CW = 8;

  logic             i_clk = 1'b0;
  logic             i_rst_n;
  logic [CW-1:0]    i_cfg_num_terms;
  logic             i_cfg_sat_en;
  logic [AW-1:0]    i_bias;
  logic             i_clear;
  logic             i_valid;
  logic             o_ready;
  logic [NL*IW-1:0] i_data;
  logic             o_valid;
  logic             i_ready;
  logic [NL*AW-1:0] o_data;
  logic [NL-1:0]    o_overflow;
  logic [CW-1:0]    o_term_cnt;

  typedef struct {
    logic [63:0] data;
    logic [3:0]  ovf;
  } exp_t;

  exp_t   q[$];
  exp_t   mon_e;
  int     n_cmp = 0;
  int     n_err = 0;
  int     m_cnt = 0;
  int     m_num = 1;
  bit     m_sat = 1'b0;
  longint m_acc[NL];
  logic [3:0] m_ovf;

  accum_array #(
    .IN_WIDTH (IW),
    .ACC_WIDTH(AW),
    .N_LANE   (NL),
    .CNT_WIDTH(CW)
  ) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_cfg_num_terms(i_cfg_num_terms),
    .i_cfg_sat_en   (i_cfg_sat_en),
    .i_bias         (i_bias),
    .i_clear        (i_clear),
    .i_valid        (i_valid),
    .o_ready        (o_ready),
    .i_data         (i_data),
    .o_valid        (o_valid),
    .i_ready        (i_ready),
    .o_data         (o_data),
    .o_overflow     (o_overflow),
    .o_term_cnt     (o_term_cnt)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] vec(input int a, input int b, input int c, input int d);
    return {d[15:0], c[15:0], b[15:0], a[15:0]};
  endfunction

  // Reference model: it is called for every accepted term, right after the accepting edge.
  task automatic model_accept(input logic [63:0] d);
    longint t, base, s;
    logic signed [15:0] w;
    bit ov;
    exp_t e;
    if (m_cnt == 0) begin
      m_num = (i_cfg_num_terms == 8'd0) ? 1 : int'(i_cfg_num_terms);
      m_sat = i_cfg_sat_en;
    end
    for (int k = 0; k < NL; k++) begin
      w = d[k*16 +: 16];
      t = w;
      if (m_cnt == 0) begin
        w = i_bias;
        base = w;
        m_ovf[k] = 1'b0;
      end else begin
        base = m_acc[k];
      end
      s  = base + t;
      ov = (s > 32767) || (s < -32768);
      if (ov && m_sat) begin
        m_acc[k] = (s > 0) ? 32767 : -32768;
      end else begin
        w = s[15:0];
        m_acc[k] = w;
      end
      m_ovf[k] = m_ovf[k] | ov;
    end
    m_cnt++;
    if (m_cnt == m_num) begin
      for (int k = 0; k < NL; k++) e.data[k*16 +: 16] = m_acc[k][15:0];
      e.ovf = m_ovf;
      q.push_back(e);
      m_cnt = 0;
    end
  endtask

  task automatic set_cfg(input int n, input bit s, input logic [15:0] b);
    i_cfg_num_terms = n[7:0];
    i_cfg_sat_en    = s;
    i_bias          = b;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  // Present one term vector and wait (with a bound) until the DUT accepts it.
  task automatic send(input logic [63:0] d);
    bit got;
    bit rdy;
    got = 1'b0;
    i_valid = 1'b1;
    i_data  = d;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge i_clk);
      rdy = o_ready;
      @(posedge i_clk);
      #1;
      if (rdy) begin
        model_accept(d);
        got = 1'b1;
      end
    end
    i_valid = 1'b0;
    check("send_accept", {63'd0, got}, 64'd1);
  endtask

  // Scoreboard monitor. It compares on every output transfer (the sample is taken at the negedge before the transfer edge).
  always @(negedge i_clk) begin
    if (i_rst_n === 1'b1 && o_valid === 1'b1 && i_ready === 1'b1) begin
      check("sb_has_entry", {63'd0, q.size() != 0}, 64'd1);
      if (q.size() != 0) begin
        mon_e = q.pop_front();
        check("out_data", o_data, mon_e.data);
        check("out_ovf", {60'd0, o_overflow}, {60'd0, mon_e.ovf});
      end
    end
  end

  initial begin
    i_rst_n = 1'b0;
    i_clear = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b1;
    i_data  = 64'd0;
    set_cfg(1, 1'b0, 16'd0);
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;

    // Reset state
    check("rst_valid", {63'd0, o_valid}, 64'd0);
    check("rst_data", o_data, 64'd0);
    check("rst_ovf", {60'd0, o_overflow}, 64'd0);
    check("rst_cnt", {56'd0, o_term_cnt}, 64'd0);
    check("rst_ready", {63'd0, o_ready}, 64'd1);

    // Basic group: bias 10, three terms
    set_cfg(3, 1'b0, 16'd10);
    send(vec(1, -1, 100, 5));
    send(vec(2, -2, 200, 5));
    check("basic_cnt2", {56'd0, o_term_cnt}, 64'd2);
    check("basic_novalid", {63'd0, o_valid}, 64'd0);
    send(vec(3, -3, 300, 5));
    check("basic_latency", {63'd0, o_valid}, 64'd1);
    check("basic_lane0", {48'd0, o_data[15:0]}, 64'd16);
    check("basic_cnt0", {56'd0, o_term_cnt}, 64'd0);
    idle(1);
    check("basic_pulse", {63'd0, o_valid}, 64'd0);

    // Back-pressure: two groups of two with i_ready low
    i_ready = 1'b0;
    set_cfg(2, 1'b0, 16'd0);
    send(vec(1, 1, 1, 1));
    send(vec(2, 2, 2, 2));
    check("bp_valid_a", {63'd0, o_valid}, 64'd1);
    send(vec(10, 20, 30, 40));
    check("bp_cnt_b", {56'd0, o_term_cnt}, 64'd1);
    i_valid = 1'b1;
    i_data  = vec(5, 5, 5, 5);
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      check("bp_stall", {63'd0, o_ready}, 64'd0);
      check("bp_hold", o_data, q[0].data);
      @(posedge i_clk);
      #1;
    end
    i_ready = 1'b1;
    @(negedge i_clk);
    check("bp_release", {63'd0, o_ready}, 64'd1);
    @(posedge i_clk);
    #1;
    model_accept(vec(5, 5, 5, 5));
    i_valid = 1'b0;
    check("bp_valid_b", {63'd0, o_valid}, 64'd1);
    check("bp_lane3_b", {48'd0, o_data[63:48]}, 64'd45);
    idle(1);
    check("bp_drain", {63'd0, o_valid}, 64'd0);

    // Saturation and wrap
    set_cfg(1, 1'b1, 16'h7FF0);
    send(vec(16'h0100, 1, 16'h0100, 0));
    check("sat_lane0", {48'd0, o_data[15:0]}, 64'h7FFF);
    check("sat_ovf", {60'd0, o_overflow}, 64'h5);
    set_cfg(1, 1'b0, 16'h7FF0);
    send(vec(16'h0100, 1, 16'h0100, 0));
    check("wrap_lane0", {48'd0, o_data[15:0]}, 64'h80F0);
    check("wrap_ovf0", {63'd0, o_overflow[0]}, 64'd1);
    set_cfg(3, 1'b1, 16'h7FF0);
    send(vec(16'h0100, 1, 0, -1));
    send(vec(-512, 1, 0, -1));
    send(vec(0, 1, 0, -1));
    check("sticky_ovf0", {63'd0, o_overflow[0]}, 64'd1);
    set_cfg(1, 1'b0, 16'd0);
    send(vec(1, 1, 1, 1));
    check("ovf_clears", {60'd0, o_overflow}, 64'd0);

    // Negative values and the negative limit
    set_cfg(2, 1'b1, 16'hFFFB);
    send(vec(-8, -32768, 0, -1));
    send(vec(3, -32768, 0, -1));
    check("neg_lane0", {48'd0, o_data[15:0]}, 64'hFFF6);
    check("neg_clamp", {48'd0, o_data[31:16]}, 64'h8000);
    idle(2);

    // num_terms = 0 behaves as 1
    set_cfg(0, 1'b0, 16'd7);
    send(vec(1, 2, 3, 4));
    check("nt0_valid", {63'd0, o_valid}, 64'd1);
    check("nt0_lane0", {48'd0, o_data[15:0]}, 64'd8);
    idle(2);

    // A config change mid-group has no effect on that group
    set_cfg(3, 1'b0, 16'd100);
    send(vec(1, 1, 1, 1));
    set_cfg(1, 1'b1, 16'd0);
    send(vec(1, 1, 1, 1));
    check("cfg_novalid", {63'd0, o_valid}, 64'd0);
    check("cfg_cnt", {56'd0, o_term_cnt}, 64'd2);
    send(vec(1, 1, 1, 1));
    check("cfg_lane0", {48'd0, o_data[15:0]}, 64'd103);
    idle(2);

    // Clear together with a valid term mid-group
    set_cfg(4, 1'b0, 16'd0);
    send(vec(9, 9, 9, 9));
    send(vec(9, 9, 9, 9));
    check("clr_cnt_before", {56'd0, o_term_cnt}, 64'd2);
    i_clear = 1'b1;
    i_valid = 1'b1;
    i_data  = vec(100, 100, 100, 100);
    @(posedge i_clk);
    #1;
    i_clear = 1'b0;
    i_valid = 1'b0;
    m_cnt   = 0;
    check("clr_cnt", {56'd0, o_term_cnt}, 64'd0);
    check("clr_noresult", {63'd0, o_valid}, 64'd0);
    for (int i = 0; i < 4; i++) send(vec(1, 1, 1, 1));
    check("clr_restart", {48'd0, o_data[15:0]}, 64'd4);
    idle(2);

    // Reset mid-operation with o_valid=1 and counter=2
    i_ready = 1'b0;
    set_cfg(1, 1'b0, 16'd0);
    send(vec(1, 1, 1, 1));
    set_cfg(3, 1'b0, 16'd0);
    send(vec(2, 2, 2, 2));
    send(vec(2, 2, 2, 2));
    check("mr_cnt2", {56'd0, o_term_cnt}, 64'd2);
    check("mr_valid", {63'd0, o_valid}, 64'd1);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("mr_rst_valid", {63'd0, o_valid}, 64'd0);
    check("mr_rst_data", o_data, 64'd0);
    check("mr_rst_ovf", {60'd0, o_overflow}, 64'd0);
    check("mr_rst_cnt", {56'd0, o_term_cnt}, 64'd0);
    check("mr_rst_ready", {63'd0, o_ready}, 64'd1);
    q.delete();
    m_cnt = 0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    i_ready = 1'b1;
    set_cfg(1, 1'b0, 16'd50);
    send(vec(1, 2, 3, 4));
    check("mr_after_valid", {63'd0, o_valid}, 64'd1);
    check("mr_after_data", o_data, vec(51, 52, 53, 54));

    // Drain the scoreboard
    for (int i = 0; i < 20 && q.size() != 0; i++) idle(1);
    check("sb_empty", {32'd0, q.size()}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
